// File: rtl/mips_dmem_pkg.sv
// Shared types and constants for the MIPS data-memory controller.
// Four byte cycles make up one big-endian 32-bit word access.
package mips_dmem_pkg;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RD_LAST,
    DONE
  } state_t;

endpackage

// File: rtl/mips_rr_arb2.sv
// Two-requester round-robin arbiter.
// On a tie the port not granted last wins; the pointer resets to port 1.
module mips_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt_onehot
);

  logic last;

  // pick a winner; a tie goes to the port that lost last time
  always_comb begin
    gnt_onehot = req;
    unique case (1'b1)
      (req == 2'b11): gnt_onehot = last ? 2'b01 : 2'b10;
      default:        gnt_onehot = req;
    endcase
  end

  // remember which port was granted on an accepted request
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b1;
    end else if (advance && (|gnt_onehot)) begin
      last <= gnt_onehot[1];
    end
  end

endmodule

// File: rtl/mips_dmem_ctrl.sv
// Two-port word sequencer in front of a byte-wide synchronous RAM.
// Define MIPS_DMEM_ALIGN_CHK_EN to reject unaligned words with err.
module mips_dmem_ctrl
  import mips_dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [31:0]       m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [BYTE_W-1:0] mem_wdata,
  input  logic [BYTE_W-1:0] mem_rdata
`ifdef MIPS_DMEM_ALIGN_CHK_EN
  ,
  output logic              err
`endif
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  state_t              state;
  state_t              state_nx;
  logic [1:0]          gnt_vec;
  logic                gnt_sel;
  logic                accept;
  logic                unaligned;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [31:0]         req_wdata;
  logic                sel;
  logic                we_q;
  logic [31:0]         wdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          cnt;
  logic [23:0]         rbuf;
  logic [31:0]         rdata0_q;
  logic [31:0]         rdata1_q;
  logic                err_q;
  logic                unused_addr;

  assign unused_addr = ^{m0_addr[31:ADDR_W],
                         m1_addr[31:ADDR_W]};

  mips_rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        ({m1_req, m0_req}),
    .advance    (accept),
    .gnt_onehot (gnt_vec)
  );

  assign accept  = (state == IDLE) && (|gnt_vec)
                   && !reset;
  assign gnt_sel = gnt_vec[1];

  // mux the winning port's request fields
  always_comb begin
    req_we    = gnt_sel ? m1_we : m0_we;
    req_addr  = gnt_sel ? m1_addr[ADDR_W-1:0]
                        : m0_addr[ADDR_W-1:0];
    req_wdata = gnt_sel ? m1_wdata : m0_wdata;
`ifdef MIPS_DMEM_ALIGN_CHK_EN
    unaligned = gnt_sel ? (|m1_addr[1:0])
                        : (|m0_addr[1:0]);
`else
    unaligned = 1'b0;
`endif
  end

  // sequence IDLE -> XFER x4 -> (RD_LAST) -> DONE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (|gnt_vec) begin
          state_nx = unaligned ? DONE : XFER;
        end
      end
      XFER: begin
        if (cnt == LAST_IDX) begin
          state_nx = we_q ? DONE : RD_LAST;
        end
      end
      RD_LAST: state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // handshake and RAM strobes, all forced low under reset
  always_comb begin
    m0_gnt  = accept && !gnt_sel;
    m1_gnt  = accept && gnt_sel;
    m0_done = (state == DONE) && !sel && !reset;
    m1_done = (state == DONE) && sel && !reset;
    mem_we  = (state == XFER) && we_q && !reset;
  end

  // big-endian write lane: byte 0 is the top of the word
  always_comb begin
    mem_wdata = wdata_q[31:24];
    unique case (cnt)
      2'd0: mem_wdata = wdata_q[31:24];
      2'd1: mem_wdata = wdata_q[23:16];
      2'd2: mem_wdata = wdata_q[15:8];
      2'd3: mem_wdata = wdata_q[7:0];
    endcase
  end

  assign mem_addr = addr_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;

`ifdef MIPS_DMEM_ALIGN_CHK_EN
  assign err = (state == DONE) && err_q && !reset;
`endif

  // latch the request, step the byte counter, assemble read data
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sel      <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      addr_q   <= '0;
      cnt      <= '0;
      rbuf     <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        sel     <= gnt_sel;
        we_q    <= req_we;
        wdata_q <= req_wdata;
        cnt     <= '0;
        err_q   <= unaligned;
        if (!unaligned) begin
          addr_q <= req_addr;
        end
      end
      if (state == XFER) begin
        if (cnt != LAST_IDX) begin
          cnt    <= cnt + 2'd1;
          addr_q <= addr_q + ADDR_W'(1);
        end
        if (!we_q && (cnt != 2'd0)) begin
          rbuf <= {rbuf[15:0], mem_rdata};
        end
      end
      if (state == RD_LAST) begin
        if (sel) begin
          rdata1_q <= {rbuf, mem_rdata};
        end else begin
          rdata0_q <= {rbuf, mem_rdata};
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_dmem_ctrl.sv
// Directed bench for mips_dmem_ctrl with a 1024x8 sync RAM model.
// Define MIPS_DMEM_ALIGN_CHK_EN to exercise the alignment-error path.
module tb_mips_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_gnt, m0_done;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_done;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
`ifdef MIPS_DMEM_ALIGN_CHK_EN
  logic        err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int we_cnt = 0;

  logic [7:0] mem [0:1023];

  mips_dmem_ctrl #(.ADDR_W(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_done   (m0_done),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_done   (m1_done),
    .m1_rdata  (m1_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef MIPS_DMEM_ALIGN_CHK_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_we === 1'b1) we_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic access(input int p,
                        input logic we,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        output logic [31:0] rd,
                        output int lat,
                        output logic e);
    int n;
    rd = '0;
    e = 1'b0;
    @(negedge clk);
    if (p == 0) begin
      m0_req = 1'b1; m0_we = we;
      m0_addr = a; m0_wdata = wd;
    end else begin
      m1_req = 1'b1; m1_we = we;
      m1_addr = a; m1_wdata = wd;
    end
    #1;
    n = 0;
    while (!(p == 0 ? m0_gnt : m1_gnt) && n < 30) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 30) check("gnt_timeout", 32'd0, 32'd1);
    @(negedge clk);
    m0_req = 1'b0;
    m1_req = 1'b0;
    lat = 1;
    #1;
    while (!(p == 0 ? m0_done : m1_done) && lat < 30) begin
      @(negedge clk); #1; lat++;
    end
    if (lat >= 30) check("done_timeout", 32'd0, 32'd1);
    rd = (p == 0) ? m0_rdata : m1_rdata;
`ifdef MIPS_DMEM_ALIGN_CHK_EN
    e = err;
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    logic        e;
    int          w0;
    int          ng, both, n, dn;
    logic [5:0]  seqv;
    logic [31:0] held;
    logic [9:0]  a0;

    for (int i = 0; i < 1024; i++) mem[i] = i[7:0];
    reset = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt_gated", {31'd0, m0_gnt}, 32'd0);
    @(negedge clk);
    m0_req = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_done", {30'd0, m1_done, m0_done}, 32'd0);
    check("rst_m0_rdata", m0_rdata, 32'd0);
    check("rst_m1_rdata", m1_rdata, 32'd0);

    // 1: plain read
    w0 = we_cnt;
    access(0, 1'b0, 32'h10, 32'h0, rd, lat, e);
    check("t1_rdata", rd, 32'h10111213);
    check("t1_lat", lat, 32'd6);
    check("t1_no_we", we_cnt, w0);

    // 2: write then read back on the other port
    access(0, 1'b1, 32'h20, 32'hDEADBEEF, rd, lat, e);
    check("t2_wr_lat", lat, 32'd5);
    check("t2_rdata_kept", m0_rdata, 32'h10111213);
    check("t2_mem", {mem[32'h20], mem[32'h21],
                     mem[32'h22], mem[32'h23]}, 32'hDEADBEEF);
    access(1, 1'b0, 32'h20, 32'h0, rd, lat, e);
    check("t2_m1_rdata", rd, 32'hDEADBEEF);
    check("t2_rd_lat", lat, 32'd6);

    // 3: both ports held, alternating grants
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4;
    ng = 0; both = 0; n = 0; seqv = '0;
    while (ng < 6 && n < 100) begin
      #1;
      if (m0_gnt && m1_gnt) both++;
      if (m0_gnt || m1_gnt) begin
        seqv[ng] = m1_gnt;
        ng++;
      end
      @(negedge clk);
      n++;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (10) @(negedge clk);
    check("t3_ngrants", ng, 32'd6);
    check("t3_order", {26'd0, seqv}, 32'h2A);
    check("t3_both", both, 32'd0);
    check("t3_m0_rdata", m0_rdata, 32'h00010203);
    check("t3_m1_rdata", m1_rdata, 32'h04050607);

`ifndef MIPS_DMEM_ALIGN_CHK_EN
    // 4: unaligned read wrapping past the top
    access(0, 1'b0, 32'h3FE, 32'h0, rd, lat, e);
    check("t4_wrap_rdata", rd, 32'hFEFF0001);
    check("t4_lat", lat, 32'd6);
`endif

    // 5: reset during byte 2 of a write
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b1;
    m0_addr = 32'h40; m0_wdata = 32'h11223344;
    #1;
    check("t5_gnt", {31'd0, m0_gnt}, 32'd1);
    @(negedge clk);
    m0_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("t5_addr_i2", {22'd0, mem_addr}, 32'h42);
    check("t5_we_i2", {31'd0, mem_we}, 32'd1);
    reset = 1'b1;
    #1;
    check("t5_we_gated", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    repeat (8) begin
      #1;
      if (m0_done || m1_done) dn++;
      @(negedge clk);
    end
    check("t5_no_done", dn, 32'd0);
    check("t5_mem", {mem[32'h40], mem[32'h41],
                     mem[32'h42], mem[32'h43]}, 32'h11224243);
    check("t5_rst_rdata", m0_rdata, 32'd0);
    access(0, 1'b0, 32'h40, 32'h0, rd, lat, e);
    check("t5_after_rdata", rd, 32'h11224243);
    check("t5_after_lat", lat, 32'd6);

`ifdef MIPS_DMEM_ALIGN_CHK_EN
    // 6: unaligned request rejected
    access(1, 1'b0, 32'h4, 32'h0, rd, lat, e);
    held = m1_rdata;
    a0 = mem_addr;
    w0 = we_cnt;
    access(1, 1'b0, 32'h102, 32'h0, rd, lat, e);
    check("t6_lat", lat, 32'd1);
    check("t6_err", {31'd0, e}, 32'd1);
    check("t6_rdata_held", rd, held);
    check("t6_addr_kept", {22'd0, mem_addr}, {22'd0, a0});
    check("t6_no_we", we_cnt, w0);
    check("t6_held_val", held, 32'h04050607);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
